// File: rtl/sb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : sb_pkg                                                   |
// | Description : Shared sideband definitions (TX framer and RX FSM):      |
// |               state encoding, SBINIT pattern, header bit positions     |
// |               and small header field accessors.                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package sb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PATTERN = 3'd1,
    ST_HEADER  = 3'd2,
    ST_DATA    = 3'd3,
    ST_GAP     = 3'd4
  } sb_tx_state_e;

  localparam logic [63:0] SB_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

  localparam int CP_BIT      = 62;
  localparam int DP_BIT      = 63;
  localparam int MSGCODE_LSB = 14;
  localparam int DSTID_LSB   = 56;

  function automatic logic [7:0] sb_msgcode(input logic [61:0] hdr);
    return hdr[MSGCODE_LSB +: 8];
  endfunction

  function automatic logic [2:0] sb_dstid(input logic [61:0] hdr);
    return hdr[DSTID_LSB +: 3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_tx_framer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : sb_tx_framer_if                                          |
// | Description : Request (arbiter) and serializer handshake bundle of the |
// |               sideband TX framer. Names are from the framer's view.    |
// |   slave  : framer side  (requests in, serializer word/status out)      |
// |   master : environment  (arbiter + serializer)                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface sb_tx_framer_if;
  logic        i_pattern_start;
  logic        i_pattern_stop;
  logic        i_msg_valid;
  logic [61:0] i_msg_header;
  logic [63:0] i_msg_data;
  logic        i_msg_has_data;
  logic        i_ser_done;
  logic [63:0] o_ser_data;
  logic        o_ser_valid;
  logic        o_msg_ack;
  logic        o_pattern_done;
  logic        o_busy;

  modport slave (
    input  i_pattern_start, i_pattern_stop, i_msg_valid, i_msg_header,
           i_msg_data, i_msg_has_data, i_ser_done,
    output o_ser_data, o_ser_valid, o_msg_ack, o_pattern_done, o_busy
  );

  modport master (
    output i_pattern_start, i_pattern_stop, i_msg_valid, i_msg_header,
           i_msg_data, i_msg_has_data, i_ser_done,
    input  o_ser_data, o_ser_valid, o_msg_ack, o_pattern_done, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/sb_parity_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sb_parity_gen                                            |
// | Description : Combinational even-parity generator for sideband         |
// |               packets. DP covers the data word (0 when no data), CP    |
// |               covers DP plus header so the 64-bit header word is even. |
// | Ports       : i_header[61:0], i_data[63:0], i_has_data -> o_dp, o_cp   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module sb_parity_gen (
  input  wire logic [61:0] i_header,
  input  wire logic [63:0] i_data,
  input  wire logic        i_has_data,
  output logic             o_dp,
  output logic             o_cp
);

  always_comb begin
    o_dp = i_has_data & (^i_data);
    o_cp = ^{o_dp, i_header};
  end

endmodule
`default_nettype wire

// File: rtl/sb_tx_framer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sb_tx_framer                                             |
// | Description : Sideband transmit framer. Sends the SBINIT pattern,      |
// |               frames messages as header (+ optional data) words with   |
// |               CP/DP parity, and inserts the inter-packet gap. One word |
// |               is handed to the serializer at a time (valid/done).      |
// | Ports       : i_clk, i_rst (sync, active high), bus (slave modport)    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module sb_tx_framer
  import sb_pkg::*;
#(
  parameter int PATTERN_MIN = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 4
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst,
  sb_tx_framer_if.slave  bus
);

  localparam logic [CNT_W:0]   c_pat_min  = (CNT_W+1)'(PATTERN_MIN);
  localparam logic [CNT_W-1:0] c_gap_last = CNT_W'(GAP_CYCLES - 1);

  sb_tx_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_pat_cnt, w_pat_cnt_nxt;
  logic [CNT_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [63:0]       r_ser_data, w_ser_data_nxt;
  logic              r_ser_valid, w_ser_valid_nxt;
  logic              r_msg_ack, w_msg_ack_nxt;
  logic              r_pattern_done, w_pattern_done_nxt;
  logic              r_busy;
  logic [63:0]       r_data, w_data_nxt;
  logic              r_has_data, w_has_data_nxt;

  logic              w_dp, w_cp;
  logic [63:0]       w_hdr_word;
  logic [CNT_W:0]    w_pat_inc;
  logic              w_done;

  sb_parity_gen u_parity (
    .i_header   (bus.i_msg_header),
    .i_data     (bus.i_msg_data),
    .i_has_data (bus.i_msg_has_data),
    .o_dp       (w_dp),
    .o_cp       (w_cp)
  );

  always_comb begin
    w_hdr_word         = {2'b00, bus.i_msg_header};
    w_hdr_word[DP_BIT] = w_dp;
    w_hdr_word[CP_BIT] = w_cp;
  end

  // A done pulse only counts while a word is actually being offered.
  assign w_done    = bus.i_ser_done & r_ser_valid;
  // One bit wider so the "count after this word" compare cannot wrap.
  assign w_pat_inc = {1'b0, r_pat_cnt} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt        = r_state;
    w_pat_cnt_nxt      = r_pat_cnt;
    w_gap_cnt_nxt      = r_gap_cnt;
    w_ser_data_nxt     = r_ser_data;
    w_ser_valid_nxt    = r_ser_valid;
    w_msg_ack_nxt      = 1'b0;
    w_pattern_done_nxt = 1'b0;
    w_data_nxt         = r_data;
    w_has_data_nxt     = r_has_data;

    case (r_state)
      ST_IDLE: begin
        if (bus.i_pattern_start) begin
          w_state_nxt     = ST_PATTERN;
          w_pat_cnt_nxt   = '0;
          w_ser_data_nxt  = SB_PATTERN;
          w_ser_valid_nxt = 1'b1;
        end else if (bus.i_msg_valid) begin
          w_state_nxt     = ST_HEADER;
          w_data_nxt      = bus.i_msg_data;
          w_has_data_nxt  = bus.i_msg_has_data;
          w_msg_ack_nxt   = 1'b1;
          w_ser_data_nxt  = w_hdr_word;
          w_ser_valid_nxt = 1'b1;
        end
      end

      ST_PATTERN: begin
        if (w_done) begin
          if (bus.i_pattern_stop && (w_pat_inc >= c_pat_min)) begin
            w_state_nxt        = ST_GAP;
            w_gap_cnt_nxt      = '0;
            w_ser_valid_nxt    = 1'b0;
            w_pattern_done_nxt = 1'b1;
          end else if (w_pat_inc <= c_pat_min) begin
            w_pat_cnt_nxt = w_pat_inc[CNT_W-1:0];
          end
        end
      end

      ST_HEADER: begin
        if (w_done) begin
          if (r_has_data) begin
            w_state_nxt    = ST_DATA;
            w_ser_data_nxt = r_data;
          end else begin
            w_state_nxt     = ST_GAP;
            w_gap_cnt_nxt   = '0;
            w_ser_valid_nxt = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (w_done) begin
          w_state_nxt     = ST_GAP;
          w_gap_cnt_nxt   = '0;
          w_ser_valid_nxt = 1'b0;
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == c_gap_last) begin
          w_state_nxt   = ST_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_ser_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_pat_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_ser_data     <= '0;
      r_ser_valid    <= 1'b0;
      r_msg_ack      <= 1'b0;
      r_pattern_done <= 1'b0;
      r_busy         <= 1'b0;
      r_data         <= '0;
      r_has_data     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pat_cnt      <= w_pat_cnt_nxt;
      r_gap_cnt      <= w_gap_cnt_nxt;
      r_ser_data     <= w_ser_data_nxt;
      r_ser_valid    <= w_ser_valid_nxt;
      r_msg_ack      <= w_msg_ack_nxt;
      r_pattern_done <= w_pattern_done_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_data         <= w_data_nxt;
      r_has_data     <= w_has_data_nxt;
    end
  end

  assign bus.o_ser_data     = r_ser_data;
  assign bus.o_ser_valid    = r_ser_valid;
  assign bus.o_msg_ack      = r_msg_ack;
  assign bus.o_pattern_done = r_pattern_done;
  assign bus.o_busy         = r_busy;

endmodule
`default_nettype wire
